// File: rtl/ultrasonic_scheduler.sv
// Ultrasonic ranging scheduler: round-robins up to four sensors, fires a
// trigger pulse on the selected one, times its echo-high width and reports
// the result, then idles for a cooldown gap before the next measurement.
`timescale 1ns/1ps
module ultrasonic_scheduler #(
  parameter int TRIGGER_CYCLES  = 60,
  parameter int MAX_ECHO_CYCLES = 139800,
  parameter int COOLDOWN_CYCLES = 1500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  sensor_mask,
  input  logic [3:0]  echo,
  output logic [3:0]  trig,
  output logic [23:0] result,
  output logic [1:0]  result_id,
  output logic        result_timeout,
  output logic        result_valid,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_TRIGGER   = 3'd2,
    S_WAIT_ECHO = 3'd3,
    S_MEASURE   = 3'd4,
    S_COOLDOWN  = 3'd5
  } state_e;

  localparam logic [23:0] TRIG_LAST = 24'(TRIGGER_CYCLES - 1);
  localparam logic [23:0] ECHO_MAX  = 24'(MAX_ECHO_CYCLES);
  localparam logic [23:0] ECHO_LAST = 24'(MAX_ECHO_CYCLES - 1);
  localparam logic [23:0] COOL_LAST = 24'(COOLDOWN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] cnt_inc;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  echo_s1_q, echo_s2_q;
  logic        echo_sel;
  logic [23:0] result_q, result_d;
  logic [1:0]  id_q, id_d;
  logic        to_q, to_d;
  logic        valid_q, valid_d;

  // First set mask bit strictly after ptr, wrapping 3->0; ptr itself is
  // checked last so a single-sensor mask keeps picking the same sensor.
  function automatic logic [1:0] next_pick(input logic [1:0] ptr, input logic [3:0] mask);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign echo_sel = echo_s2_q[sel_q];
  // Saturating increment so no counter can ever wrap.
  assign cnt_inc  = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;

  // Two-flop synchronizer on every raw echo line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
    end
  end

  // State, counter, round-robin pointer and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd3;
      result_q <= '0;
      id_q     <= '0;
      to_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      id_q     <= id_d;
      to_q     <= to_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic; every report loads the result registers and enters
  // COOLDOWN on the same edge, so result_valid coincides with COOLDOWN entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    result_d = result_q;
    id_d     = id_q;
    to_d     = to_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (sensor_mask != 4'd0)) begin
          state_d = S_SELECT;
          cnt_d   = '0;
        end
      end
      S_SELECT: begin
        if (sensor_mask == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          sel_d   = next_pick(sel_q, sensor_mask);
          state_d = S_TRIGGER;
          cnt_d   = '0;
        end
      end
      S_TRIGGER: begin
        if (cnt_q >= TRIG_LAST) begin
          state_d = S_WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_ECHO: begin
        if (echo_sel) begin
          // The cycle that shows the rise is the first echo-high cycle.
          state_d = S_MEASURE;
          cnt_d   = 24'd1;
        end else if (cnt_q >= ECHO_LAST) begin
          state_d  = S_COOLDOWN;
          cnt_d    = '0;
          result_d = '0;
          id_d     = sel_q;
          to_d     = 1'b1;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEASURE: begin
        if (!echo_sel) begin
          state_d  = S_COOLDOWN;
          cnt_d    = '0;
          result_d = cnt_q;
          id_d     = sel_q;
          to_d     = 1'b0;
          valid_d  = 1'b1;
        end else if (cnt_q >= ECHO_LAST) begin
          state_d  = S_COOLDOWN;
          cnt_d    = '0;
          result_d = ECHO_MAX;
          id_d     = sel_q;
          to_d     = 1'b1;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_COOLDOWN: begin
        if (cnt_q >= COOL_LAST) begin
          state_d = enable ? S_SELECT : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Trigger is decoded from registered state, so an async reset clears it
  // immediately without waiting for a clock edge.
  always_comb begin
    trig = 4'd0;
    if (state_q == S_TRIGGER) trig[sel_q] = 1'b1;
  end

  assign busy           = (state_q != S_IDLE);
  assign result         = result_q;
  assign result_id      = id_q;
  assign result_timeout = to_q;
  assign result_valid   = valid_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with short timing parameters.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  sensor_mask;
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic [23:0] result;
  logic [1:0]  result_id;
  logic        result_timeout;
  logic        result_valid;
  logic        busy;
  logic [2:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int s2_trigs = 0;

  ultrasonic_scheduler #(
    .TRIGGER_CYCLES (4),
    .MAX_ECHO_CYCLES(20),
    .COOLDOWN_CYCLES(10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sensor_mask   (sensor_mask),
    .echo          (echo),
    .trig          (trig),
    .result        (result),
    .result_id     (result_id),
    .result_timeout(result_timeout),
    .result_valid  (result_valid),
    .busy          (busy),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count any trigger pulse on sensor 2
  always @(negedge clk) if (trig[2]) s2_trigs++;

  // Hard time limit
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_first;
    logic [3:0]  mask;
    int          echo_w;
    logic [3:0]  echo_pat;
    logic [3:0]  exp_trig;
    logic [23:0] exp_res;
    logic [1:0]  exp_id;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] mask);
    echo        = 4'd0;
    enable      = 1'b0;
    sensor_mask = mask;
    rst_n       = 1'b0;
    tick();
    tick();
    check("reset_result", {8'd0, result}, 32'd0);
    check("reset_ctrl", {20'd0, trig, result_id, result_timeout, result_valid, busy, dbg_state_o}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  // Wait for a trigger pulse, return its pattern and length.
  task automatic wait_trig(output logic [3:0] pat, output int len);
    int   n;
    logic stable;
    n = 0;
    while (trig == 4'd0 && n < 60) begin
      tick();
      n++;
    end
    check("trig_rise_timeout", {31'd0, (trig == 4'd0)}, 32'd0);
    pat    = trig;
    len    = 0;
    stable = 1'b1;
    while (trig != 4'd0 && len < 20) begin
      if (trig !== pat) stable = 1'b0;
      tick();
      len++;
    end
    check("trig_stable", {31'd0, stable}, 32'd1);
  endtask

  task automatic run_measure(input vec_t v);
    logic [3:0] pat;
    int         len;
    int         lat;
    logic       seen;
    wait_trig(pat, len);
    check("trig_sel", {28'd0, pat}, {28'd0, v.exp_trig});
    check("trig_len", len, 4);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      echo = (lat < v.echo_w) ? v.echo_pat : 4'd0;
      tick();
      lat++;
      if (result_valid) seen = 1'b1;
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
    check("report_latency", lat, v.exp_lat);
    check("result", {8'd0, result}, {8'd0, v.exp_res});
    check("result_id", {30'd0, result_id}, {30'd0, v.exp_id});
    check("result_timeout", {31'd0, result_timeout}, {31'd0, v.exp_to});
    echo = (lat < v.echo_w) ? v.echo_pat : 4'd0;
    tick();
    lat++;
    check("valid_one_cycle", {31'd0, result_valid}, 32'd0);
    check("result_hold", {8'd0, result}, {8'd0, v.exp_res});
    while (lat < v.echo_w) begin
      echo = v.echo_pat;
      tick();
      lat++;
    end
    echo = 4'd0;
  endtask

  initial begin
    logic [3:0] pat;
    int         len;
    int         lat;
    int         n;
    int         cnt;
    int         s2_before;
    logic       seen;
    vec_t       v;

    rst_n       = 1'b0;
    enable      = 1'b0;
    sensor_mask = 4'd0;
    echo        = 4'd0;

    //          rst   mask     w   pat      trig     res    id    to    lat
    vecs[0] = '{1'b1, 4'b0001, 7,  4'b0001, 4'b0001, 24'd7,  2'd0, 1'b0, 10};
    vecs[1] = '{1'b0, 4'b0001, 0,  4'b0001, 4'b0001, 24'd0,  2'd0, 1'b1, 20};
    vecs[2] = '{1'b0, 4'b0001, 50, 4'b0001, 4'b0001, 24'd20, 2'd0, 1'b1, 22};
    vecs[3] = '{1'b1, 4'b1011, 3,  4'b1111, 4'b0001, 24'd3,  2'd0, 1'b0, 6};
    vecs[4] = '{1'b0, 4'b1011, 4,  4'b1111, 4'b0010, 24'd4,  2'd1, 1'b0, 7};
    vecs[5] = '{1'b0, 4'b1011, 5,  4'b1111, 4'b1000, 24'd5,  2'd3, 1'b0, 8};
    vecs[6] = '{1'b0, 4'b1011, 6,  4'b1111, 4'b0001, 24'd6,  2'd0, 1'b0, 9};

    s2_before = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) begin
        do_reset(vecs[i].mask);
        s2_before = s2_trigs;
      end
      run_measure(vecs[i]);
    end
    check("sensor2_never_triggered", s2_trigs - s2_before, 0);

    // Enable dropped during MEASURE: report still made, then IDLE after cooldown.
    do_reset(4'b0001);
    wait_trig(pat, len);
    check("en_trig_sel", {28'd0, pat}, 32'd1);
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      echo = 4'b0001;
      tick();
      lat++;
    end
    check("en_in_measure", {29'd0, dbg_state_o}, 32'd4);
    enable = 1'b0;
    seen   = 1'b0;
    while (!seen && lat < 100) begin
      echo = (lat < 6) ? 4'b0001 : 4'd0;
      tick();
      lat++;
      if (result_valid) seen = 1'b1;
    end
    echo = 4'd0;
    check("en_valid_seen", {31'd0, seen}, 32'd1);
    check("en_latency", lat, 9);
    check("en_result", {8'd0, result}, 32'd6);
    check("en_timeout", {31'd0, result_timeout}, 32'd0);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("en_cooldown_len", n, 10);
    check("en_idle_state", {29'd0, dbg_state_o}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy || trig != 4'd0) cnt++;
    end
    check("en_stays_idle", cnt, 0);

    // Reset during TRIGGER: trig drops at once, nothing reported, next pick is 0.
    do_reset(4'b0111);
    v = '{1'b0, 4'b0111, 3, 4'b0001, 4'b0001, 24'd3, 2'd0, 1'b0, 6};
    run_measure(v);
    n = 0;
    while (trig == 4'd0 && n < 60) begin
      tick();
      n++;
    end
    check("rst_trig_sel1", {28'd0, trig}, 32'b0010);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_trig_async_drop", {28'd0, trig}, 32'd0);
    check("rst_busy_drop", {31'd0, busy}, 32'd0);
    cnt = 0;
    tick();
    if (result_valid) cnt++;
    tick();
    if (result_valid) cnt++;
    rst_n = 1'b1;
    n = 0;
    while (trig == 4'd0 && n < 60) begin
      tick();
      n++;
      if (result_valid) cnt++;
    end
    check("rst_no_valid", cnt, 0);
    check("rst_result_cleared", {8'd0, result}, 32'd0);
    check("rst_next_pick", {28'd0, trig}, 32'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ultrasonic_scheduler.md
ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 The block SHALL have parameter TRIGGER_CYCLES, default 60, giving the trigger pulse length in clk cycles.
REQ-002 The block SHALL have parameter MAX_ECHO_CYCLES, default 139800, giving the echo-wait limit and the echo-high limit in cycles.
REQ-003 The block SHALL have parameter COOLDOWN_CYCLES, default 1500000, giving the idle gap after each measurement.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1, which permits new measurement cycles.
REQ-007 The block SHALL have port sensor_mask, input, 4, where bit i=1 includes sensor i in the rotation.
REQ-008 The block SHALL have port echo, input, 4, the raw echo lines from sensors 0-3.
REQ-009 The block SHALL have port trig, output, 4, the trigger lines to sensors 0-3.
REQ-010 The block SHALL have port result, output, 24, the measured echo-high width in cycles.
REQ-011 The block SHALL have port result_id, output, 2, the sensor index of result.
REQ-012 The block SHALL have port result_timeout, output, 1, flagging that result was clipped or had no echo.
REQ-013 The block SHALL have port result_valid, output, 1, a single-cycle pulse when result, result_id and result_timeout update.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 Each echo bit SHALL pass through a 2-flop synchronizer; all echo decisions use synchronized values (2-cycle input latency).
REQ-016 FSM states SHALL be IDLE, SELECT, TRIGGER, WAIT_ECHO, MEASURE, COOLDOWN; unused encodings go to IDLE.
REQ-017 IDLE -> SELECT SHALL occur when enable=1 and sensor_mask!=0; otherwise the FSM stays in IDLE.
REQ-018 SELECT SHALL take one cycle to pick the next sensor, round-robin: the first set mask bit after the previous index, wrapping 3->0, starting from index 0 after reset.
REQ-019 SELECT SHALL return to IDLE if the mask becomes 0 in that cycle; the mask is sampled only in SELECT.
REQ-020 TRIGGER SHALL drive trig[sel]=1 for exactly TRIGGER_CYCLES cycles, with all other trig bits 0, then enter WAIT_ECHO.
REQ-021 trig SHALL be 0 in every state other than TRIGGER.
REQ-022 WAIT_ECHO SHALL enter MEASURE when synchronized echo[sel] rises; after MAX_ECHO_CYCLES cycles without a rise it reports result=0 with result_timeout=1 and enters COOLDOWN.
REQ-023 MEASURE SHALL count cycles while echo[sel]=1; on the fall it reports result=count with result_timeout=0.
REQ-024 MEASURE SHALL, when the count reaches MAX_ECHO_CYCLES, report result=MAX_ECHO_CYCLES with result_timeout=1, whether or not echo is still high.
REQ-025 Every report SHALL update result, result_id and result_timeout and pulse result_valid for one cycle, in the same cycle as the transition to COOLDOWN.
REQ-026 result, result_id and result_timeout SHALL hold their values between reports.
REQ-027 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then go to SELECT if enable=1, else to IDLE.
REQ-028 Deasserting enable mid-cycle SHALL NOT abort the measurement in progress; it takes effect at the end of COOLDOWN.
REQ-029 Echo activity on unselected sensors SHALL be ignored.
REQ-030 All counters SHALL be 24 bits and saturate, never wrapping.

Reset
REQ-031 While rst_n=0 the block SHALL hold: state=IDLE, trig=0, result=0, result_id=0, result_timeout=0, result_valid=0, busy=0, counters=0, synchronizers=0, round-robin pointer=3 so that the next pick is index 0.
REQ-032 Reset asserted mid-operation SHALL drop trig to 0 immediately, without waiting for a clock edge, and discard the measurement in progress.

Verification (TRIGGER_CYCLES=4, MAX_ECHO_CYCLES=20, COOLDOWN_CYCLES=10)
REQ-033 The bench SHALL cover: mask=0001, enable=1, echo[0] high 7 cycles after trigger -> trig[0] high 4 cycles; result=7, result_id=0, result_timeout=0, one-cycle result_valid.
REQ-034 The bench SHALL cover: mask=1011 with echo present on every sensor -> result_id sequence 0,1,3,0, and trig never pulses on sensor 2.
REQ-035 The bench SHALL cover: echo never rises -> result=0, result_timeout=1 after 20 WAIT_ECHO cycles.
REQ-036 The bench SHALL cover: echo held high for 50 cycles -> result=20, result_timeout=1.
REQ-037 The bench SHALL cover: enable dropped during MEASURE -> result still reported, then IDLE with busy=0 after 10 cooldown cycles.
REQ-038 The bench SHALL cover: rst_n pulsed low during TRIGGER -> trig=0 at once, no result_valid, and the next pick after release is sensor 0.
